// File: rtl/mouse_receiver.sv
// rtl/mouse_receiver.sv - PS/2 mouse frame receiver with synchronizers, parity/stop check and timeout
//
// Receives 11-bit PS/2 frames: start 0, 8 data bits LSB first, odd parity, stop 1.
// Ports:
//   CLK             system clock, rising edge
//   RESET           asynchronous active-low reset
//   CLK_MOUSE_IN    PS/2 clock from the mouse (asynchronous)
//   DATA_MOUSE_IN   PS/2 data from the mouse (asynchronous)
//   READ_ENABLE     1 = a new frame may be started
//   BYTE_READ       last received data byte
//   BYTE_ERROR_CODE bit0 parity error, bit1 stop-bit error
//   BYTE_READY      one-cycle strobe, BYTE_READ/BYTE_ERROR_CODE valid
module mouse_receiver #(
    parameter int TIMEOUT     = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   ps2_clk;
    logic                   ps2_data;
    logic                   fall;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic        par_err, par_err_n;
    logic        stop_err, stop_err_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic        timed_out;
    logic [7:0]  byte_n;
    logic [1:0]  code_n;
    logic        ready_n;

    // Bus idles high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync[0]  <= CLK_MOUSE_IN;
            data_sync[0] <= DATA_MOUSE_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign ps2_clk   = clk_sync[SYNC_STAGES-1];
    assign ps2_data  = data_sync[SYNC_STAGES-1];
    assign fall      = clk_prev & ~ps2_clk;
    assign timed_out = (tcnt == TW'(TIMEOUT));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shift           <= '0;
            par_err         <= 1'b0;
            stop_err        <= 1'b0;
            tcnt            <= '0;
            BYTE_READ       <= '0;
            BYTE_ERROR_CODE <= '0;
            BYTE_READY      <= 1'b0;
        end else begin
            state           <= state_n;
            bit_cnt         <= bit_cnt_n;
            shift           <= shift_n;
            par_err         <= par_err_n;
            stop_err        <= stop_err_n;
            tcnt            <= tcnt_n;
            BYTE_READ       <= byte_n;
            BYTE_ERROR_CODE <= code_n;
            BYTE_READY      <= ready_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        par_err_n  = par_err;
        stop_err_n = stop_err;
        tcnt_n     = tcnt;
        byte_n     = BYTE_READ;
        code_n     = BYTE_ERROR_CODE;
        ready_n    = 1'b0;

        case (state)
            IDLE: begin
                tcnt_n = '0;
                // A start bit sampled high is not a frame; stay idle.
                if (fall && READ_ENABLE && !ps2_data) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            START_CHK: begin
                // Start validation is folded into IDLE; kept only as a safe exit.
                state_n = IDLE;
                tcnt_n  = '0;
            end
            DATA, PARITY, STOP: begin
                // An edge wins over a coincident timeout.
                if (fall) begin
                    tcnt_n = '0;
                    if (state == DATA) begin
                        shift_n[bit_cnt[2:0]] = ps2_data;
                        bit_cnt_n             = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) state_n = PARITY;
                    end else if (state == PARITY) begin
                        par_err_n = ~((^shift) ^ ps2_data);
                        state_n   = STOP;
                    end else begin
                        stop_err_n = ~ps2_data;
                        state_n    = DONE;
                    end
                end else if (timed_out) begin
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            DONE: begin
                byte_n  = shift;
                code_n  = {stop_err, par_err};
                ready_n = 1'b1;
                tcnt_n  = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                tcnt_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mouse_receiver.sv
// tb/tb_mouse_receiver.sv - scoreboard bench for mouse_receiver with randomized PS/2 frames
module tb_mouse_receiver;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       read_en;
    logic [7:0] byte_read;
    logic [1:0] err_code;
    logic       byte_ready;

    int n_checks = 0;
    int n_fails  = 0;
    logic [9:0] sb[$];
    logic [7:0] last_byte;

    always #5 clk = ~clk;

    mouse_receiver #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
        .CLK             (clk),
        .RESET           (rst_n),
        .CLK_MOUSE_IN    (ps2_clk),
        .DATA_MOUSE_IN   (ps2_data),
        .READ_ENABLE     (read_en),
        .BYTE_READ       (byte_read),
        .BYTE_ERROR_CODE (err_code),
        .BYTE_READY      (byte_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && byte_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_pulse: got byte %0h code %0h expected no pulse", byte_read, err_code);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                if ({byte_read, err_code} !== e) begin
                    n_fails++;
                    $display("FAIL frame: got byte %0h code %0h expected byte %0h code %0h",
                             byte_read, err_code, e[9:2], e[1:0]);
                end
            end
        end
    end

    // Reference: odd parity means data ones plus parity bit must be odd.
    function automatic logic [9:0] expect_frame(input logic [7:0] d, input logic par, input logic stp);
        logic perr;
        perr = ((($countones(d) + int'(par)) % 2) == 0);
        return {d, !stp, perr};
    endfunction

    // Drive nedges falling edges of a frame; a complete enabled frame is scored.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int nedges, input logic drop_re);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        if (nedges == 11 && read_en) begin
            sb.push_back(expect_frame(d, par, stp));
            last_byte = d;
        end
        for (int i = 0; i < nedges; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            if (drop_re && i == 0) read_en = 1'b0;
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        read_en = 1'b1;
    endtask

    task automatic check_drained(input string name);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        read_en  = 1'b1;
        last_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_byte", byte_read, 8'h00);
        check("reset_code", err_code, 2'b00);
        check("reset_ready", byte_ready, 1'b0);
        @(posedge clk);
        rst_n = 1'b1;

        // Disabled frame is ignored entirely.
        read_en = 1'b0;
        send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0);
        check("disabled_byte", byte_read, 8'h00);
        check_drained("disabled_drain");

        send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0);
        check_drained("fa_drain");
        send_frame(8'h08, 1'b1, 1'b1, 11, 1'b0);
        check_drained("parity_err_drain");
        send_frame(8'h08, 1'b0, 1'b0, 11, 1'b0);
        check_drained("stop_err_drain");
        check("hold_code", err_code, 2'b10);

        // Partial frame abandoned by timeout.
        send_frame(8'h3C, 1'b1, 1'b1, 5, 1'b0);
        repeat (TIMEOUT + 10) @(posedge clk);
        send_frame(8'hAA, 1'b1, 1'b1, 11, 1'b0);
        check_drained("timeout_drain");

        // Reset mid-frame discards the partial frame.
        send_frame(8'hC3, 1'b1, 1'b1, 5, 1'b0);
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("midreset_out", {byte_read, err_code, byte_ready}, 11'h0);
        end
        @(posedge clk);
        rst_n = 1'b1;
        send_frame(8'h55, 1'b1, 1'b1, 11, 1'b0);
        check_drained("reset_drain");

        // READ_ENABLE dropped after the start bit: frame still completes.
        send_frame(8'h96, 1'b1, 1'b1, 11, 1'b1);
        check_drained("re_drop_drain");

        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, p, s, 11, 1'b0);
            check_drained("random_drain");
        end

        repeat (50) @(posedge clk);
        @(negedge clk);
        check("hold_byte", byte_read, last_byte);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mouse_receiver.md
MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 Parameter TIMEOUT, default 50000, sets the CLK cycles allowed between PS/2 clock falling edges within a frame (1 ms at 50 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of flip-flop synchronizer stages on CLK_MOUSE_IN and DATA_MOUSE_IN.
REQ-003 CLK  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 CLK_MOUSE_IN  input  1  PS/2 clock from the mouse, asynchronous to CLK.
REQ-006 DATA_MOUSE_IN  input  1  PS/2 data from the mouse, asynchronous to CLK.
REQ-007 READ_ENABLE  input  1  from the master SM; 1 = frame reception allowed.
REQ-008 BYTE_READ  output  8  last received data byte.
REQ-009 BYTE_ERROR_CODE  output  2  bit0 = parity error; bit1 = stop-bit error.
REQ-010 BYTE_READY  output  1  one-cycle strobe: BYTE_READ and BYTE_ERROR_CODE are valid.

Function
REQ-011 Both PS/2 inputs SHALL pass through SYNC_STAGES flops before any use.
REQ-012 A PS/2 clock falling edge SHALL be detected as previous synced sample 1 and current synced sample 0, giving a one-cycle internal strobe.
REQ-013 The FSM SHALL have the states IDLE, START_CHK, DATA, PARITY, STOP and DONE.
REQ-014 IDLE: on an edge with READ_ENABLE=1 and synced data=0 (start bit), go to DATA with bit count 0; otherwise stay in IDLE.
REQ-015 IDLE with READ_ENABLE=0: edges are ignored and no shift register update occurs.
REQ-016 IDLE with start bit sampled 1: the frame is invalid; stay in IDLE with no BYTE_READY.
REQ-017 DATA: on each edge, shift synced data into bit [count] (LSB first) and increment count; after the 8th bit (count 7) go to PARITY.
REQ-018 PARITY: on an edge, capture the parity bit; parity error = NOT(XOR of 8 data bits XOR parity bit), i.e. odd parity is expected; go to STOP.
REQ-019 STOP: on an edge, stop error = NOT(synced data); go to DONE.
REQ-020 DONE: for exactly one cycle, load BYTE_READ and BYTE_ERROR_CODE and drive BYTE_READY=1; next state is IDLE.
REQ-021 Latency: BYTE_READY SHALL rise on the second CLK edge after the cycle in which the stop-bit edge strobe is high.
REQ-022 BYTE_READY SHALL be asserted even with an error code; the master decides whether to discard the byte.
REQ-023 BYTE_READ and BYTE_ERROR_CODE SHALL hold their values until the next DONE or reset.
REQ-024 READ_ENABLE deasserted mid-frame: the current frame SHALL complete normally (no abort).
REQ-025 Timeout counter: clear on every edge strobe and in IDLE; increment in DATA, PARITY and STOP.
REQ-026 When the timeout counter reaches TIMEOUT, go to IDLE on the next CLK edge, with no BYTE_READY and outputs unchanged.
REQ-027 An edge in the same cycle as the timeout SHALL take priority: the edge is processed and the counter is cleared.
REQ-028 Bit counter width SHALL be 4 bits.
REQ-029 Timeout counter width SHALL be the minimum that holds TIMEOUT, and it SHALL never wrap.

Reset
REQ-030 With RESET=0, the block SHALL immediately enter IDLE, with no clock required.
REQ-031 With RESET=0: BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, BYTE_READY=0, counters=0, shift register=0, synchronizer flops=1 (bus idle high).
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait for a new start bit.
REQ-033 No BYTE_READY SHALL be produced in the first cycle after reset release.

Verification
REQ-034 READ_ENABLE=1; frame start 0, data 0xFA LSB first, parity 1, stop 1, 20 us PS/2 period -> one BYTE_READY pulse, BYTE_READ=0xFA, BYTE_ERROR_CODE=00.
REQ-035 Frame with data 0x08, parity 1 (wrong), stop 1 -> BYTE_READY pulse, BYTE_READ=0x08, BYTE_ERROR_CODE=01.
REQ-036 Frame with data 0x08, parity 0, stop 0 -> BYTE_READY pulse, BYTE_ERROR_CODE=10.
REQ-037 READ_ENABLE=0 and a full valid 0xFA frame -> no BYTE_READY; BYTE_READ stays 0x00.
REQ-038 Start plus 4 data bits, then no edges for TIMEOUT+10 cycles, then a full 0xAA frame -> no pulse for the partial frame; one pulse with BYTE_READ=0xAA and code 00.
REQ-039 RESET=0 after data bit 3 of a frame, released 5 cycles later, then a full 0x55 frame -> outputs 0 during reset; exactly one pulse with BYTE_READ=0x55.
